bc_control_unit: RTL and testbench

- Hardwired control sequencer for the 16-bit basic computer.
- Drives BUS_SEL and CTRL_SGNLS into the data path, and reads back IR, AC, DR and E to make decisions.
- Contains the timing counter (T0..T6) and the instruction decode for memory-reference and register-reference instructions.
- Outputs are a Moore decode of registered state: asserted for the whole of cycle Tn; data-path registers update on the clk edge that ends Tn.

---
 rtl/bc_control_unit.sv | 211 +++++++++++++++++++++
 tb/tb_bc_control_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/bc_control_unit.sv
// bc_control_unit: hardwired T0..T6 sequencer and instruction decoder for the 16-bit basic computer.
// Optional STEP_MODE_EN: pause after each instruction until a STEP pulse.
module bc_control_unit #(
  parameter int WIDTH      = 16,
  parameter int CTRL_LNGTH = 20
) (
  input  logic                  clk,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic                  STEP,
  input  logic [WIDTH-1:0]      IR,
  input  logic [WIDTH-1:0]      AC,
  input  logic [WIDTH-1:0]      DR,
  input  logic                  E,
  output logic [2:0]            BUS_SEL,
  output logic [CTRL_LNGTH-1:0] CTRL_SGNLS,
  output logic [1:0]            E_CTRL,
  output logic [2:0]            SC,
  output logic                  RUNNING,
  output logic                  HALTED
);
  localparam int LD_AR  = 0;
  localparam int INR_AR = 1;
  localparam int LD_PC  = 3;
  localparam int INR_PC = 4;
  localparam int LD_DR  = 6;
  localparam int INR_DR = 7;
  localparam int LD_AC  = 9;
  localparam int INR_AC = 10;
  localparam int CLR_AC = 11;
  localparam int LD_IR  = 12;
  localparam int MEM_WE = 16;
  localparam int ALU_LO = 17;
  localparam logic [2:0] B_AR  = 3'd0;
  localparam logic [2:0] B_PC  = 3'd1;
  localparam logic [2:0] B_DR  = 3'd2;
  localparam logic [2:0] B_AC  = 3'd3;
  localparam logic [2:0] B_IR  = 3'd4;
  localparam logic [2:0] B_MEM = 3'd6;

`ifdef STEP_MODE_EN
  typedef enum logic [1:0] {IDLE, RUN, HALT, PAUSE} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  logic step_unused;
  assign step_unused = STEP;
`endif

  state_t     state_q, state_d;
  logic [2:0] sc_q, sc_d;
  logic [2:0] d;
  logic       ind, reg_ref, hlt, done;
  logic [2:0]            bus;
  logic [CTRL_LNGTH-1:0] ctl;
  logic [1:0]            ec;

  assign d       = IR[14:12];
  assign ind     = IR[15];
  assign reg_ref = (d == 3'd7) && !ind;
  assign hlt     = (state_q == RUN) && (sc_q == 3'd3) && reg_ref && (IR[11:0] == 12'h001);

  // Last step of each instruction; SC=7 is folded in so it can never stick.
  assign done = ((sc_q == 3'd3) && (d == 3'd7)) ||
                ((sc_q == 3'd4) && ((d == 3'd3) || (d == 3'd4))) ||
                ((sc_q == 3'd5) && ((d <= 3'd2) || (d == 3'd5))) ||
                (sc_q >= 3'd6);

  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    case (state_q)
      IDLE, HALT: if (START) begin
        state_d = RUN;
        sc_d    = 3'd0;
      end
      RUN: begin
        sc_d = done ? 3'd0 : sc_q + 3'd1;
`ifdef STEP_MODE_EN
        state_d = hlt ? HALT : done ? PAUSE : RUN;
`else
        state_d = hlt ? HALT : RUN;
`endif
      end
`ifdef STEP_MODE_EN
      PAUSE: if (STEP) begin
        state_d = RUN;
        sc_d    = 3'd0;
      end
`endif
      default: begin
        state_d = IDLE;
        sc_d    = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      sc_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
    end
  end

  // Control decode is gated by RUN so reset clears every pulse at once.
  always_comb begin
    bus = B_AR;
    ctl = '0;
    ec  = 2'b00;
    if (state_q == RUN) begin
      case (sc_q)
        3'd0: begin
          bus        = B_PC;
          ctl[LD_AR] = 1'b1;
        end
        3'd1: begin
          bus         = B_MEM;
          ctl[LD_IR]  = 1'b1;
          ctl[INR_PC] = 1'b1;
        end
        3'd2: begin
          bus        = B_IR;
          ctl[LD_AR] = 1'b1;
        end
        3'd3: begin
          if (d != 3'd7 && ind) begin
            bus        = B_MEM;
            ctl[LD_AR] = 1'b1;
          end else if (reg_ref) begin
            casez (IR[11:0])
              12'b1???????????: ctl[CLR_AC] = 1'b1;
              12'b01??????????: ec = 2'b01;
              12'b001?????????: begin
                ctl[ALU_LO+:3] = 3'b011;
                ctl[LD_AC]     = 1'b1;
              end
              12'b0001????????: ec = 2'b10;
              12'b00001???????: begin
                ctl[ALU_LO+:3] = 3'b100;
                ctl[LD_AC]     = 1'b1;
                ec             = 2'b11;
              end
              12'b000001??????: begin
                ctl[ALU_LO+:3] = 3'b101;
                ctl[LD_AC]     = 1'b1;
                ec             = 2'b11;
              end
              12'b0000001?????: ctl[INR_AC] = 1'b1;
              12'b00000001????: ctl[INR_PC] = !AC[WIDTH-1];
              12'b000000001???: ctl[INR_PC] = AC[WIDTH-1];
              12'b0000000001??: ctl[INR_PC] = (AC == '0);
              12'b00000000001?: ctl[INR_PC] = !E;
              default: ctl = '0;
            endcase
          end
        end
        3'd4: begin
          case (d)
            3'd3: begin
              bus         = B_AC;
              ctl[MEM_WE] = 1'b1;
            end
            3'd4: ctl[LD_PC] = 1'b1;
            3'd5: begin
              bus         = B_PC;
              ctl[MEM_WE] = 1'b1;
              ctl[INR_AR] = 1'b1;
            end
            3'd7: ctl = '0;
            default: begin
              bus        = B_MEM;
              ctl[LD_DR] = 1'b1;
            end
          endcase
        end
        3'd5: begin
          case (d)
            3'd0: ctl[LD_AC] = 1'b1;
            3'd1: begin
              ctl[ALU_LO+:3] = 3'b001;
              ctl[LD_AC]     = 1'b1;
              ec             = 2'b11;
            end
            3'd2: begin
              ctl[ALU_LO+:3] = 3'b010;
              ctl[LD_AC]     = 1'b1;
            end
            3'd5: ctl[LD_PC] = 1'b1;
            3'd6: ctl[INR_DR] = 1'b1;
            default: ctl = '0;
          endcase
        end
        3'd6: if (d == 3'd6) begin
          bus         = B_DR;
          ctl[MEM_WE] = 1'b1;
          ctl[INR_PC] = (DR == '0);
        end
        default: ctl = '0;
      endcase
    end
  end

  assign BUS_SEL    = bus;
  assign CTRL_SGNLS = ctl;
  assign E_CTRL     = ec;
  assign SC         = sc_q;
  assign RUNNING    = (state_q == RUN);
  assign HALTED     = (state_q == HALT);
endmodule

// File: tb/tb_bc_control_unit.sv
// tb_bc_control_unit: directed-vector bench for bc_control_unit.
module tb_bc_control_unit;
  logic        clk = 1'b0;
  logic        rst_n, start, step, e;
  logic [15:0] ir, ac, dr;
  logic [2:0]  bus_sel, sc;
  logic [19:0] ctrl;
  logic [1:0]  e_ctrl;
  logic        running, halted;
  int n_cmp = 0;
  int n_bad = 0;

  bc_control_unit dut (
    .clk(clk), .RST_N(rst_n), .START(start), .STEP(step),
    .IR(ir), .AC(ac), .DR(dr), .E(e),
    .BUS_SEL(bus_sel), .CTRL_SGNLS(ctrl), .E_CTRL(e_ctrl),
    .SC(sc), .RUNNING(running), .HALTED(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic adv(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; step = 1'b0; e = 1'b0;
    ir = 16'h7000; ac = 16'h0000; dr = 16'h0000;
    adv(2);
    chk("rst_ctrl", ctrl, 0);
    chk("rst_bus", bus_sel, 0);
    chk("rst_sc", sc, 0);
    chk("rst_run", running, 0);
    chk("rst_halt", halted, 0);
    rst_n = 1'b1;
    adv(1);
    chk("idle_ctrl", ctrl, 0);
    // NOP register-reference fetch
    start = 1'b1;
    adv(1);
    start = 1'b0;
    chk("t0_bus", bus_sel, 1);
    chk("t0_ctrl", ctrl, 20'h00001);
    chk("t0_run", running, 1);
    adv(1);
    chk("t1_bus", bus_sel, 6);
    chk("t1_ctrl", ctrl, 20'h01010);
    adv(1);
    chk("t2_bus", bus_sel, 4);
    chk("t2_ctrl", ctrl, 20'h00001);
    adv(1);
    chk("nop_t3_sc", sc, 3);
    chk("nop_t3_ctrl", ctrl, 0);
    adv(1);
    chk("nop_end_sc", sc, 0);
    // ADD direct; START in RUN must be ignored
    ir = 16'h1050;
    start = 1'b1;
    adv(1);
    start = 1'b0;
    chk("start_ignored_sc", sc, 1);
    adv(2);
    chk("add_t3_ctrl", ctrl, 0);
    adv(1);
    chk("add_t4_bus", bus_sel, 6);
    chk("add_t4_ctrl", ctrl, 20'h00040);
    adv(1);
    chk("add_t5_ctrl", ctrl, 20'h20200);
    chk("add_t5_e", e_ctrl, 3);
    adv(1);
    chk("add_end_sc", sc, 0);
    // ISZ indirect, DR reaches zero
    ir = 16'hE0AA;
    adv(3);
    chk("isz_t3_bus", bus_sel, 6);
    chk("isz_t3_ctrl", ctrl, 20'h00001);
    adv(1);
    chk("isz_t4_ctrl", ctrl, 20'h00040);
    adv(1);
    chk("isz_t5_ctrl", ctrl, 20'h00080);
    adv(1);
    dr = 16'h0000;
    #1;
    chk("isz_t6_bus", bus_sel, 2);
    chk("isz_t6_zero", ctrl, 20'h10010);
    adv(1);
    chk("isz_end_sc", sc, 0);
    // ISZ again, DR nonzero: no skip
    adv(6);
    dr = 16'h0005;
    #1;
    chk("isz_t6_sc", sc, 6);
    chk("isz_t6_nz", ctrl, 20'h10000);
    adv(1);
    // SZA with AC zero / nonzero
    ir = 16'h7004; ac = 16'h0000;
    adv(3);
    chk("sza_zero", ctrl, 20'h00010);
    adv(1);
    ac = 16'h0001;
    adv(3);
    chk("sza_nz", ctrl, 0);
    adv(1);
    ir = 16'h7A00;
    adv(3);
    chk("cla_prio", ctrl, 20'h00800);
    chk("cla_prio_e", e_ctrl, 0);
    adv(1);
    ir = 16'h7080;
    adv(3);
    chk("cir_ctrl", ctrl, 20'h80200);
    chk("cir_e", e_ctrl, 3);
    adv(1);
    // STA and BSA
    ir = 16'h3000;
    adv(4);
    chk("sta_bus", bus_sel, 3);
    chk("sta_ctrl", ctrl, 20'h10000);
    adv(1);
    chk("sta_end_sc", sc, 0);
    ir = 16'h5000;
    adv(4);
    chk("bsa_t4_bus", bus_sel, 1);
    chk("bsa_t4_ctrl", ctrl, 20'h10002);
    adv(1);
    chk("bsa_t5_ctrl", ctrl, 20'h00008);
    chk("bsa_t5_bus", bus_sel, 0);
    adv(1);
    // HLT then restart
    ir = 16'h7001;
    adv(3);
    chk("hlt_t3_ctrl", ctrl, 0);
    adv(1);
    chk("hlt_halted", halted, 1);
    chk("hlt_run", running, 0);
    chk("hlt_bus", bus_sel, 0);
    adv(2);
    chk("hlt_stays", halted, 1);
    chk("hlt_sc", sc, 0);
    ir = 16'h1050;
    start = 1'b1;
    adv(1);
    start = 1'b0;
    chk("restart_bus", bus_sel, 1);
    chk("restart_halt", halted, 0);
    // Reset during T5 of ADD
    adv(5);
    chk("pre_rst_ctrl", ctrl, 20'h20200);
    rst_n = 1'b0;
    #1;
    chk("abort_ctrl", ctrl, 0);
    chk("abort_sc", sc, 0);
    chk("abort_run", running, 0);
    chk("abort_e", e_ctrl, 0);
    @(posedge clk);
    chk("abort_edge_ctrl", ctrl, 0);
    #1;
    rst_n = 1'b1;
    adv(2);
    chk("post_rst_idle", running, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
